// File: rtl/cpu_ctrl_fsm_if.sv
// rtl/cpu_ctrl_fsm_if.sv - control bus between cpu_ctrl_fsm and the 16-bit datapath
// Optional step_req input exists only when CTRL_SINGLE_STEP_EN is defined.
interface cpu_ctrl_fsm_if;
    logic [15:0] ram_out;
    logic [4:0]  flags_in;
`ifdef CTRL_SINGLE_STEP_EN
    logic        step_req;
`endif
    logic        pc_en;
    logic        pc_mux_selct;
    logic [15:0] pc_add_k;
    logic        en_a;
    logic        ram_we;
    logic        lsc_mux_selct;
    logic        reg_we;
    logic [3:0]  reg_waddr;
    logic [3:0]  Rdest_select;
    logic [3:0]  Rsrc_select;
    logic        Imm_select;
    logic [15:0] Imm_out;
    logic [7:0]  opcode;
    logic        fsm_alu_mem_selct;
    logic [15:0] ir_out;
    logic        halted;

    modport master (
        input  ram_out, flags_in,
`ifdef CTRL_SINGLE_STEP_EN
        input  step_req,
`endif
        output pc_en, pc_mux_selct, pc_add_k, en_a, ram_we, lsc_mux_selct,
               reg_we, reg_waddr, Rdest_select, Rsrc_select, Imm_select,
               Imm_out, opcode, fsm_alu_mem_selct, ir_out, halted
    );

    modport slave (
        output ram_out, flags_in,
`ifdef CTRL_SINGLE_STEP_EN
        output step_req,
`endif
        input  pc_en, pc_mux_selct, pc_add_k, en_a, ram_we, lsc_mux_selct,
               reg_we, reg_waddr, Rdest_select, Rsrc_select, Imm_select,
               Imm_out, opcode, fsm_alu_mem_selct, ir_out, halted
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle fetch/decode/exec/mem/wb control FSM for the 16-bit CPU
// Optional single-step mode is enabled by defining CTRL_SINGLE_STEP_EN.
module cpu_ctrl_fsm #(
    parameter int RESET_PC_HOLD = 0
) (
    input logic            clk,
    input logic            reset,
    cpu_ctrl_fsm_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t      state, state_n;
    logic [15:0] ir;
    logic [4:0]  flags_reg;
    logic [3:0]  hold_cnt;
    logic        fetch_ok;

    logic [3:0]  op, rd, ext, rs;
    logic [15:0] imm_sext;
    logic        is_imm, is_alu, is_cmp, is_load, is_stor, is_branch, is_halt;
    logic        taken;

    assign op       = ir[15:12];
    assign rd       = ir[11:8];
    assign ext      = ir[7:4];
    assign rs       = ir[3:0];
    assign imm_sext = {{8{ir[7]}}, ir[7:0]};

    assign is_imm    = op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'hD};
    assign is_alu    = (op == 4'h0) || is_imm;
    assign is_cmp    = ((op == 4'h0) && (ext == 4'hB)) || (op == 4'hB);
    assign is_load   = (op == 4'h4) && (ext == 4'h0);
    assign is_stor   = (op == 4'h4) && (ext == 4'h4);
    assign is_branch = (op == 4'hC);
    assign is_halt   = (op == 4'hF);

    // flags_reg = {C, L, F, Z, N}; condition code lives in the rd field
    always_comb begin
        taken = 1'b0;
        case (rd)
            4'h0: taken = flags_reg[1];
            4'h1: taken = !flags_reg[1];
            4'h2: taken = flags_reg[4];
            4'h3: taken = !flags_reg[4];
            4'h4: taken = flags_reg[0];
            4'h5: taken = !flags_reg[0];
            4'h6: taken = flags_reg[2];
            4'h7: taken = !flags_reg[2];
            4'hE: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

`ifdef CTRL_SINGLE_STEP_EN
    logic step_q, step_armed;

    // One instruction per rising edge of step_req, however long it is held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q     <= 1'b0;
            step_armed <= 1'b0;
        end else begin
            step_q <= bus.step_req;
            if (state == S_FETCH && fetch_ok)
                step_armed <= 1'b0;
            else if (bus.step_req && !step_q)
                step_armed <= 1'b1;
        end
    end

    assign fetch_ok = (hold_cnt == 4'd0) && step_armed;
`else
    assign fetch_ok = (hold_cnt == 4'd0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            ir        <= 16'h0000;
            flags_reg <= 5'b00000;
            hold_cnt  <= 4'(RESET_PC_HOLD);
        end else begin
            state <= state_n;
            if (state == S_DECODE)
                ir <= bus.ram_out;
            if (state == S_EXEC && is_alu)
                flags_reg <= bus.flags_in;
            if (state == S_FETCH && hold_cnt != 4'd0)
                hold_cnt <= hold_cnt - 4'd1;
        end
    end

    always_comb begin
        state_n               = state;
        bus.pc_en             = 1'b0;
        bus.pc_mux_selct      = 1'b0;
        bus.pc_add_k          = 16'h0000;
        bus.en_a              = 1'b0;
        bus.ram_we            = 1'b0;
        bus.lsc_mux_selct     = 1'b0;
        bus.reg_we            = 1'b0;
        bus.reg_waddr         = 4'h0;
        bus.Rdest_select      = 4'h0;
        bus.Rsrc_select       = 4'h0;
        bus.Imm_select        = 1'b0;
        bus.Imm_out           = 16'h0000;
        bus.opcode            = 8'h00;
        bus.fsm_alu_mem_selct = 1'b0;
        bus.ir_out            = ir;
        bus.halted            = 1'b0;

        case (state)
            S_FETCH: begin
                if (fetch_ok) begin
                    bus.en_a = 1'b1;
                    state_n  = S_DECODE;
                end
            end
            S_DECODE: state_n = S_EXEC;
            S_EXEC: begin
                state_n = S_FETCH;
                if (is_alu) begin
                    bus.Rdest_select = rd;
                    bus.Rsrc_select  = rs;
                    bus.reg_we       = !is_cmp;
                    bus.reg_waddr    = rd;
                    bus.opcode       = is_imm ? {op, 4'h0} : {op, ext};
                    bus.Imm_select   = is_imm;
                    bus.Imm_out      = is_imm ? imm_sext : 16'h0000;
                    bus.pc_en        = 1'b1;
                end else if (is_load) begin
                    bus.Rsrc_select   = rs;
                    bus.lsc_mux_selct = 1'b1;
                    bus.en_a          = 1'b1;
                    state_n           = S_MEM;
                end else if (is_stor) begin
                    bus.Rdest_select  = rd;
                    bus.Rsrc_select   = rs;
                    bus.lsc_mux_selct = 1'b1;
                    bus.en_a          = 1'b1;
                    bus.ram_we        = 1'b1;
                    bus.pc_en         = 1'b1;
                end else if (is_branch) begin
                    bus.pc_mux_selct = taken;
                    bus.pc_add_k     = taken ? imm_sext : 16'h0000;
                    bus.pc_en        = 1'b1;
                end else if (is_halt) begin
                    state_n = S_HALT;
                end else begin
                    bus.pc_en = 1'b1;
                end
            end
            S_MEM: begin
                bus.lsc_mux_selct = 1'b1;
                bus.Rsrc_select   = rs;
                state_n           = S_WB;
            end
            S_WB: begin
                bus.fsm_alu_mem_selct = 1'b1;
                bus.reg_we            = 1'b1;
                bus.reg_waddr         = rd;
                bus.pc_en             = 1'b1;
                state_n               = S_FETCH;
            end
            S_HALT: bus.halted = 1'b1;
            default: state_n = S_FETCH;
        endcase

        // Reset is asynchronous, so strobes must drop the moment it rises
        if (reset) begin
            bus.pc_en             = 1'b0;
            bus.pc_mux_selct      = 1'b0;
            bus.pc_add_k          = 16'h0000;
            bus.en_a              = 1'b0;
            bus.ram_we            = 1'b0;
            bus.lsc_mux_selct     = 1'b0;
            bus.reg_we            = 1'b0;
            bus.reg_waddr         = 4'h0;
            bus.Rdest_select      = 4'h0;
            bus.Rsrc_select       = 4'h0;
            bus.Imm_select        = 1'b0;
            bus.Imm_out           = 16'h0000;
            bus.opcode            = 8'h00;
            bus.fsm_alu_mem_selct = 1'b0;
            bus.ir_out            = 16'h0000;
            bus.halted            = 1'b0;
        end
    end
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - directed self-checking bench for cpu_ctrl_fsm
module tb_cpu_ctrl_fsm;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc;
    logic [15:0] mem [256];
    int          errors = 0;
    int          checks = 0;

    cpu_ctrl_fsm_if bus ();

    cpu_ctrl_fsm #(.RESET_PC_HOLD(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    wire [3:0]  strobes = {bus.pc_en, bus.reg_we, bus.ram_we, bus.en_a};
    wire [76:0] all_out = {bus.pc_en, bus.pc_mux_selct, bus.pc_add_k, bus.en_a, bus.ram_we,
                           bus.lsc_mux_selct, bus.reg_we, bus.reg_waddr, bus.Rdest_select,
                           bus.Rsrc_select, bus.Imm_select, bus.Imm_out, bus.opcode,
                           bus.fsm_alu_mem_selct, bus.ir_out, bus.halted};

    // Minimal datapath: PC register plus instruction RAM read on PC-addressed fetches
    always @(posedge clk or posedge reset) begin
        if (reset) pc <= 16'h0000;
        else if (bus.pc_en) pc <= bus.pc_mux_selct ? pc + bus.pc_add_k : pc + 16'd1;
    end

    always @(posedge clk) begin
        if (bus.en_a && !bus.lsc_mux_selct) bus.ram_out <= mem[pc[7:0]];
    end

    task automatic load_prog(input logic [15:0] i0, input logic [15:0] i1);
        for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
        mem[0] = i0;
        mem[1] = i1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        load_prog(16'h8000, 16'h8000);
        bus.flags_in = 5'b00000;
        reset = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (all_out !== 77'd0) begin
            errors++; $display("FAIL reset_outputs got=%h want=0", all_out);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.en_a, bus.lsc_mux_selct, bus.ir_out} !== {1'b1, 1'b0, 16'h0000}) begin
            errors++; $display("FAIL reset_release_fetch got en_a=%b lsc=%b ir=%h want 1 0 0000",
                               bus.en_a, bus.lsc_mux_selct, bus.ir_out);
        end
    endtask

    task automatic test_alu_back_to_back();
        load_prog(16'h5105, 16'h0251);
        bus.flags_in = 5'b00000;
        do_reset();
        checks++;
        if (bus.en_a !== 1'b1) begin
            errors++; $display("FAIL addi_fetch en_a got=%b want=1", bus.en_a);
        end
        next_cycle();
        checks++;
        if (strobes !== 4'b0000) begin
            errors++; $display("FAIL addi_decode strobes got=%b want=0000", strobes);
        end
        next_cycle();
        checks++;
        if ({bus.reg_we, bus.reg_waddr, bus.Imm_out, bus.opcode, bus.Imm_select, bus.pc_en,
             bus.pc_mux_selct, bus.fsm_alu_mem_selct} !==
            {1'b1, 4'd1, 16'h0005, 8'h50, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL addi_exec got we=%b wa=%h imm=%h op=%h isel=%b pc_en=%b want 1 1 0005 50 1 1",
                               bus.reg_we, bus.reg_waddr, bus.Imm_out, bus.opcode, bus.Imm_select, bus.pc_en);
        end
        next_cycle();
        checks++;
        if (strobes !== 4'b0001) begin
            errors++; $display("FAIL add_fetch strobes got=%b want=0001", strobes);
        end
        next_cycle();
        next_cycle();
        checks++;
        if ({bus.opcode, bus.Rdest_select, bus.Rsrc_select, bus.Imm_select, bus.reg_we,
             bus.reg_waddr, bus.ir_out} !== {8'h05, 4'd2, 4'd1, 1'b0, 1'b1, 4'd2, 16'h0251}) begin
            errors++; $display("FAIL add_exec got op=%h rd=%h rs=%h isel=%b we=%b wa=%h ir=%h want 05 2 1 0 1 2 0251",
                               bus.opcode, bus.Rdest_select, bus.Rsrc_select, bus.Imm_select,
                               bus.reg_we, bus.reg_waddr, bus.ir_out);
        end
    endtask

    task automatic run_branch(input logic [4:0] flags, input logic [15:0] br,
                              input logic exp_sel, input logic [15:0] exp_k);
        load_prog(16'h00B0, br);
        bus.flags_in = flags;
        do_reset();
        next_cycle();
        next_cycle();
        checks++;
        if ({bus.reg_we, bus.pc_en, bus.opcode} !== {1'b0, 1'b1, 8'h0B}) begin
            errors++; $display("FAIL cmp_exec got we=%b pc_en=%b op=%h want 0 1 0B",
                               bus.reg_we, bus.pc_en, bus.opcode);
        end
        next_cycle();
        bus.flags_in = ~flags;
        next_cycle();
        next_cycle();
        checks++;
        if ({bus.pc_en, bus.pc_mux_selct, bus.reg_we} !== {1'b1, exp_sel, 1'b0} ||
            (exp_sel && bus.pc_add_k !== exp_k)) begin
            errors++; $display("FAIL branch_%h_flags_%b got pc_en=%b sel=%b k=%h want 1 %b %h",
                               br, flags, bus.pc_en, bus.pc_mux_selct, bus.pc_add_k, exp_sel, exp_k);
        end
    endtask

    task automatic test_branch();
        run_branch(5'b00010, 16'hC0FD, 1'b1, 16'hFFFD);
        run_branch(5'b00000, 16'hC0FD, 1'b0, 16'hFFFD);
        run_branch(5'b00010, 16'hC1FD, 1'b0, 16'hFFFD);
        run_branch(5'b00000, 16'hC1FD, 1'b1, 16'hFFFD);
        run_branch(5'b10000, 16'hC205, 1'b1, 16'h0005);
        run_branch(5'b00000, 16'hCE7F, 1'b1, 16'h007F);
        run_branch(5'b11111, 16'hC8FD, 1'b0, 16'hFFFD);
    endtask

    task automatic test_load();
        int pc_en_cnt;
        load_prog(16'h4301, 16'h8000);
        bus.flags_in = 5'b00000;
        do_reset();
        pc_en_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            pc_en_cnt += int'(bus.pc_en);
            if (c == 2) begin
                checks++;
                if ({bus.lsc_mux_selct, bus.en_a, bus.Rsrc_select, bus.reg_we, bus.ram_we} !==
                    {1'b1, 1'b1, 4'd1, 1'b0, 1'b0}) begin
                    errors++; $display("FAIL load_exec got lsc=%b en_a=%b rs=%h we=%b rwe=%b want 1 1 1 0 0",
                                       bus.lsc_mux_selct, bus.en_a, bus.Rsrc_select, bus.reg_we, bus.ram_we);
                end
            end
            if (c == 3) begin
                checks++;
                if ({bus.lsc_mux_selct, bus.Rsrc_select, bus.reg_we, bus.pc_en} !== {1'b1, 4'd1, 1'b0, 1'b0}) begin
                    errors++; $display("FAIL load_mem got lsc=%b rs=%h we=%b pc_en=%b want 1 1 0 0",
                                       bus.lsc_mux_selct, bus.Rsrc_select, bus.reg_we, bus.pc_en);
                end
            end
            if (c == 4) begin
                checks++;
                if ({bus.fsm_alu_mem_selct, bus.reg_we, bus.reg_waddr, bus.pc_en} !== {1'b1, 1'b1, 4'd3, 1'b1}) begin
                    errors++; $display("FAIL load_wb got mem_sel=%b we=%b wa=%h pc_en=%b want 1 1 3 1",
                                       bus.fsm_alu_mem_selct, bus.reg_we, bus.reg_waddr, bus.pc_en);
                end
            end
            next_cycle();
        end
        checks++;
        if ({pc_en_cnt[3:0], bus.en_a, bus.lsc_mux_selct} !== {4'd1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL load_latency got pc_en_count=%0d en_a=%b lsc=%b want 1 1 0",
                               pc_en_cnt, bus.en_a, bus.lsc_mux_selct);
        end
    endtask

    task automatic test_store();
        int we_cnt;
        int bad;
        load_prog(16'h4241, 16'h8000);
        bus.flags_in = 5'b00000;
        do_reset();
        we_cnt = 0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            we_cnt += int'(bus.ram_we);
            if (bus.reg_we || (bus.ram_we && !bus.lsc_mux_selct)) bad++;
            if (c == 2) begin
                checks++;
                if ({bus.ram_we, bus.lsc_mux_selct, bus.en_a, bus.Rdest_select, bus.Rsrc_select, bus.pc_en} !==
                    {1'b1, 1'b1, 1'b1, 4'd2, 4'd1, 1'b1}) begin
                    errors++; $display("FAIL stor_exec got rwe=%b lsc=%b en_a=%b rd=%h rs=%h pc_en=%b want 1 1 1 2 1 1",
                                       bus.ram_we, bus.lsc_mux_selct, bus.en_a, bus.Rdest_select,
                                       bus.Rsrc_select, bus.pc_en);
                end
            end
            next_cycle();
        end
        checks++;
        if (we_cnt !== 1 || bad !== 0) begin
            errors++; $display("FAIL stor_single got ram_we_count=%0d bad_cycles=%0d want 1 0", we_cnt, bad);
        end
    endtask

    task automatic test_halt();
        int bad;
        load_prog(16'hF000, 16'h5105);
        bus.flags_in = 5'b00000;
        do_reset();
        next_cycle();
        next_cycle();
        checks++;
        if ({strobes, bus.halted} !== 5'b00000) begin
            errors++; $display("FAIL halt_exec got strobes=%b halted=%b want 0000 0", strobes, bus.halted);
        end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            if (bus.halted !== 1'b1 || strobes !== 4'b0000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL halt_hold got bad_cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_reset_mid_load();
        load_prog(16'h4301, 16'h8000);
        bus.flags_in = 5'b00000;
        do_reset();
        for (int c = 0; c < 4; c++) next_cycle();
        checks++;
        if (bus.reg_we !== 1'b1) begin
            errors++; $display("FAIL midreset_wb got reg_we=%b want 1", bus.reg_we);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (all_out !== 77'd0) begin
            errors++; $display("FAIL midreset_async_drop got=%h want=0", all_out);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.ir_out, bus.en_a, bus.halted, bus.reg_we} !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL midreset_release got ir=%h en_a=%b halted=%b we=%b want 0000 1 0 0",
                               bus.ir_out, bus.en_a, bus.halted, bus.reg_we);
        end
    endtask

    initial begin
        bus.ram_out  = 16'h0000;
        bus.flags_in = 5'b00000;
        test_reset();
        test_alu_back_to_back();
        test_branch();
        test_load();
        test_store();
        test_halt();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle control FSM that sequences the 16-bit datapath through fetch, decode, execute, memory and writeback phases. It drives every datapath select and enable: PC, RAM port A, load/store address mux, register file, Rdest/Rsrc/immediate muxes, ALU opcode and the ALU/memory writeback mux. It holds the instruction register and the latched ALU flags used for conditional branches.

Parameters:
RESET_PC_HOLD, 0, number of cycles after reset deassertion that the FSM holds in S_FETCH without asserting en_a (0..15).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
ram_out  in  16  RAM port A read data; valid one cycle after en_a
flags_in  in  5  ALU flags {C,L,F,Z,N}, combinational from current ALU operands
pc_en  out  1  PC load strobe
pc_mux_selct  out  1  0 = PC+1, 1 = PC+pc_add_k
pc_add_k  out  16  sign-extended branch displacement
en_a  out  1  RAM port A enable
ram_we  out  1  RAM port A write enable
lsc_mux_selct  out  1  RAM address source: 0 = PC, 1 = register
reg_we  out  1  register file write strobe
reg_waddr  out  4  register file write index
Rdest_select  out  4  Rdest mux select
Rsrc_select  out  4  Rsrc mux select
Imm_select  out  1  1 = immediate replaces Rsrc
Imm_out  out  16  sign-extended imm8
opcode  out  8  ALU opcode
fsm_alu_mem_selct  out  1  writeback source: 0 = ALU, 1 = RAM
ir_out  out  16  current instruction register
halted  out  1  high while in S_HALT

Behaviour:
- Reset: state S_FETCH, ir = 0, flags_reg = 0, hold counter = RESET_PC_HOLD. All outputs are 0.
- Instruction fields: op = ir[15:12], rd = ir[11:8], ext = ir[7:4], rs = ir[3:0], imm8 = ir[7:0].
- Decode classes:
  - op 0x0: register ALU operation; ALU opcode = {op, ext}.
  - op in {1,2,3,5,6,7,9,B,D}: immediate form; ALU opcode = {op, 4'h0}, Imm_select = 1, Imm_out = sext(imm8).
  - CMP (op 0, ext B) and CMPI (op B): no writeback.
  - op 4, ext 0: LOAD rd <- [rs].
  - op 4, ext 4: STOR [rs] <- rd.
  - op C: Bcond, cond = rd, disp = imm8.
  - op F: HALT.
  - Anything else: NOP.
- S_FETCH: lsc_mux_selct = 0, en_a = 1. Go to S_DECODE. While the hold counter is nonzero, en_a = 0, the counter decrements and the FSM stays in S_FETCH.
- S_DECODE: ir <- ram_out. Go to S_EXEC.
- S_EXEC, per class:
  - ALU: Rdest_select = rd, Rsrc_select = rs, reg_we = 1 (except compares), reg_waddr = rd, fsm_alu_mem_selct = 0. flags_reg <- flags_in (compares included). pc_en = 1, pc_mux_selct = 0. Go to S_FETCH.
  - LOAD: Rsrc_select = rs, lsc_mux_selct = 1, en_a = 1. Go to S_MEM.
  - STOR: Rdest_select = rd (data), Rsrc_select = rs (address), lsc_mux_selct = 1, en_a = 1, ram_we = 1, pc_en = 1. Go to S_FETCH.
  - Bcond: if taken, pc_mux_selct = 1 and pc_add_k = sext(disp); otherwise pc_mux_selct = 0. pc_en = 1. Go to S_FETCH.
  - HALT: go to S_HALT.
  - NOP: pc_en = 1. Go to S_FETCH.
- S_MEM: lsc_mux_selct = 1, Rsrc_select = rs. Go to S_WB.
- S_WB: fsm_alu_mem_selct = 1, reg_we = 1, reg_waddr = rd, pc_en = 1. Go to S_FETCH.
- S_HALT: all strobes 0, halted = 1. Exit only by reset.
- Branch conditions (using flags_reg):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 GT: N
  - 5 LE: !N
  - 6 FS: F
  - 7 FC: !F
  - E UC: always
  - others: never taken
- Latency: ALU/STOR/branch/NOP = 3 cycles; LOAD = 5 cycles.
- Strobe timing: pc_en, reg_we and ram_we are single-cycle, one per instruction. ram_we is never asserted concurrently with lsc_mux_selct = 0.
- PC arithmetic wraps modulo 2^16.
- Reset mid-instruction: all strobes drop immediately (asynchronous); no partial write is issued after reset.

Optional Feature:
CTRL_SINGLE_STEP_EN
- Enabled: adds input step_req (1 bit). The FSM waits in S_FETCH with en_a = 0 until step_req is sampled high, then executes exactly one instruction. A held step_req runs exactly one instruction per rising edge of step_req.
- Disabled: no port is added and the FSM free-runs.

Test Plan:
- Release reset, RAM[0] = 16'h5105 (ADDI r1, 5) -> en_a at cycle 0; reg_we = 1, reg_waddr = 1, Imm_out = 16'h0005, opcode = 8'h50 at cycle 2; pc_en = 1.
- RAM[1] = 16'h0251 (ADD r2, r1) -> opcode = 8'h05, Rdest_select = 2, Rsrc_select = 1, Imm_select = 0, reg_we at cycle 2 of the instruction.
- CMP with flags_in = 5'b00010 (Z), then 16'hC0FD (BEQ -3) -> pc_mux_selct = 1, pc_add_k = 16'hFFFD; with flags_in Z = 0 -> pc_mux_selct = 0. 16'hC1FD (BNE) gives the opposite results.
- 16'h4301 (LOAD r3, [r1]) -> lsc_mux_selct = 1 in S_EXEC/S_MEM; S_WB: fsm_alu_mem_selct = 1, reg_waddr = 3; total 5 cycles; single pc_en.
- 16'h4241 (STOR [r1], r2) -> ram_we = 1 for exactly one cycle with lsc_mux_selct = 1, Rdest_select = 2, Rsrc_select = 1; no reg_we.
- 16'hF000 (HALT) -> halted = 1 and no strobes for 20 cycles. Reset asserted during S_WB of a LOAD -> reg_we drops immediately; after release the FSM is in S_FETCH with ir = 0.
